calcsys_ctrl: RTL and testbench

- Sequencing FSM for the 4-bit calculator datapath.
- Captures operands and opcode into the datapath registers and starts the correct engine (small ALU, multiplier or divider).
- Waits for that engine's completion, then writes the result into the Hi/Lo output registers.
- Reports done or error to the top-level user interface.

---
 rtl/calcsys_pkg.sv | 54 +++++
 rtl/calcsys_wait_cnt.sv | 28 ++
 rtl/calcsys_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_calcsys_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/calcsys_pkg.sv
// Shared encodings for the 4-bit calculator controller: opcodes, FSM states,
// result-mux selects and ALU operation codes.
package calcsys_pkg;

  localparam logic [2:0] OP_PASSX = 3'b000;
  localparam logic [2:0] OP_PASSY = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_AND   = 3'b100;
  localparam logic [2:0] OP_OR    = 3'b101;
  localparam logic [2:0] OP_MUL   = 3'b110;
  localparam logic [2:0] OP_DIV   = 3'b111;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_LOAD      = 4'd1,
    S_DECODE    = 4'd2,
    S_CALC_GO   = 4'd3,
    S_CALC_WAIT = 4'd4,
    S_MUL_WAIT  = 4'd5,
    S_DIV_GO    = 4'd6,
    S_DIV_WAIT  = 4'd7,
    S_WRITE     = 4'd8,
    S_DONE      = 4'd9,
    S_ERR       = 4'd10
  } state_t;

  localparam logic [1:0] SEL_PASS = 2'b00;
  localparam logic [1:0] SEL_CALC = 2'b01;
  localparam logic [1:0] SEL_MUL  = 2'b10;
  localparam logic [1:0] SEL_DIV  = 2'b11;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  function automatic logic [1:0] sel_of_op(input logic [2:0] op);
    case (op)
      OP_PASSX, OP_PASSY: return SEL_PASS;
      OP_MUL:             return SEL_MUL;
      OP_DIV:             return SEL_DIV;
      default:            return SEL_CALC;
    endcase
  endfunction

  // ALU opcodes sit contiguously from OP_ADD, so the offset is the ALU op.
  function automatic logic [1:0] alu_of_op(input logic [2:0] op);
    logic [2:0] d;
    d = op - OP_ADD;
    return d[1:0];
  endfunction

endpackage

// File: rtl/calcsys_wait_cnt.sv
// Wait/latency counter: synchronous clear, increment, and a compare against
// a caller-supplied limit. Shared by the multiplier latency and engine timeout.
module calcsys_wait_cnt #(
  parameter int CW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  input  logic [CW-1:0] limit,
  output logic          at_lim
);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  assign at_lim = (count == limit);

endmodule

// File: rtl/calcsys_ctrl.sv
// Sequencing FSM for the 4-bit calculator: loads operands, starts the right
// engine, waits for completion or timeout, and writes Hi/Lo.
//
//   state     | meaning
//   IDLE      | waiting for a go rising edge
//   LOAD      | X/Y/F registers load
//   DECODE    | registered OP valid, pick engine
//   CALC_GO   | single-cycle ALU start
//   CALC_WAIT | wait for done_calc or timeout
//   MUL_WAIT  | fixed multiplier latency
//   DIV_GO    | single-cycle divider start
//   DIV_WAIT  | wait for done_div or timeout
//   WRITE     | Hi/Lo load
//   DONE      | done pulse
//   ERR       | error held until go drops
module calcsys_ctrl
  import calcsys_pkg::*;
#(
  parameter int MUL_LAT = 3,
  parameter int TIMEOUT = 32,
  parameter int CW      = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic [2:0] OP,
  input  logic       err_in,
  input  logic       done_calc,
  input  logic       done_div,
  output logic       x_en,
  output logic       y_en,
  output logic       f_en,
  output logic       hi_en,
  output logic       lo_en,
  output logic [1:0] sel_lo,
  output logic [1:0] sel_hi,
  output logic       sel_p,
  output logic [1:0] op_calc,
  output logic       go_calc,
  output logic       go_div,
  output logic       done,
  output logic       err,
  output logic [3:0] cs
);

  localparam logic [CW-1:0] MUL_LIM = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] TO_LIM  = CW'(TIMEOUT - 1);

  state_t        state;
  logic          go_q;
  logic          armed;
  logic          start;
  logic          cnt_clr;
  logic          cnt_inc;
  logic          at_lim;
  logic [CW-1:0] cnt_lim;

  // A go level held through reset is not a new request; require a low first.
  assign start = go & ~go_q & armed;

  assign cnt_inc = (state == S_CALC_WAIT) || (state == S_MUL_WAIT) || (state == S_DIV_WAIT);
  assign cnt_clr = ~cnt_inc;
  assign cnt_lim = (state == S_MUL_WAIT) ? MUL_LIM : TO_LIM;

  calcsys_wait_cnt #(.CW(CW)) u_wait_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr),
    .inc    (cnt_inc),
    .limit  (cnt_lim),
    .at_lim (at_lim)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      go_q    <= 1'b0;
      armed   <= 1'b0;
      x_en    <= 1'b0;
      y_en    <= 1'b0;
      f_en    <= 1'b0;
      hi_en   <= 1'b0;
      lo_en   <= 1'b0;
      go_calc <= 1'b0;
      go_div  <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      go_q    <= go;
      if (!go) armed <= 1'b1;
      x_en    <= 1'b0;
      y_en    <= 1'b0;
      f_en    <= 1'b0;
      hi_en   <= 1'b0;
      lo_en   <= 1'b0;
      go_calc <= 1'b0;
      go_div  <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && err_in) begin
            state <= S_ERR;
            err   <= 1'b1;
          end else if (start) begin
            state <= S_LOAD;
            x_en  <= 1'b1;
            y_en  <= 1'b1;
            f_en  <= 1'b1;
          end
        end
        S_LOAD: state <= S_DECODE;
        S_DECODE: begin
          if (OP[2:1] == 2'b00) begin
            state <= S_WRITE;
            hi_en <= 1'b1;
            lo_en <= 1'b1;
          end else if (OP == OP_MUL) begin
            state <= S_MUL_WAIT;
          end else if (OP == OP_DIV) begin
            state  <= S_DIV_GO;
            go_div <= 1'b1;
          end else begin
            state   <= S_CALC_GO;
            go_calc <= 1'b1;
          end
        end
        S_CALC_GO: state <= S_CALC_WAIT;
        S_CALC_WAIT: begin
          if (done_calc) begin
            state <= S_WRITE;
            hi_en <= 1'b1;
            lo_en <= 1'b1;
          end else if (at_lim) begin
            state <= S_ERR;
            err   <= 1'b1;
          end
        end
        S_MUL_WAIT: begin
          if (at_lim) begin
            state <= S_WRITE;
            hi_en <= 1'b1;
            lo_en <= 1'b1;
          end
        end
        S_DIV_GO: state <= S_DIV_WAIT;
        S_DIV_WAIT: begin
          if (done_div) begin
            state <= S_WRITE;
            hi_en <= 1'b1;
            lo_en <= 1'b1;
          end else if (at_lim) begin
            state <= S_ERR;
            err   <= 1'b1;
          end
        end
        S_WRITE: begin
          state <= S_DONE;
          done  <= 1'b1;
        end
        S_DONE: state <= S_IDLE;
        S_ERR: begin
          if (!go) state <= S_IDLE;
          else     err   <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    sel_lo  = SEL_PASS;
    sel_p   = 1'b0;
    op_calc = ALU_ADD;
    if (state != S_IDLE && state != S_LOAD) begin
      sel_lo  = sel_of_op(OP);
      sel_p   = OP[0];
      op_calc = alu_of_op(OP);
    end
  end

  assign sel_hi = sel_lo;
  assign cs     = state;

endmodule

// File: tb/tb_calcsys_ctrl.sv
// Directed bench for calcsys_ctrl with a small datapath/engine model around it.
module tb_calcsys_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       go  = 1'b0;
  logic [2:0] OP;
  logic       err_in, done_calc, done_div;
  logic       x_en, y_en, f_en, hi_en, lo_en, sel_p, go_calc, go_div, done, err;
  logic [1:0] sel_lo, sel_hi, op_calc;
  logic [3:0] cs;

  calcsys_ctrl dut (
    .clk(clk), .rst(rst), .go(go), .OP(OP), .err_in(err_in),
    .done_calc(done_calc), .done_div(done_div),
    .x_en(x_en), .y_en(y_en), .f_en(f_en), .hi_en(hi_en), .lo_en(lo_en),
    .sel_lo(sel_lo), .sel_hi(sel_hi), .sel_p(sel_p), .op_calc(op_calc),
    .go_calc(go_calc), .go_div(go_div), .done(done), .err(err), .cs(cs)
  );

  always #5 clk = ~clk;

  logic [3:0] x_in = 4'h0, y_in = 4'h0;
  logic [2:0] op_in = 3'h0;
  logic [3:0] x_r = 4'h0, y_r = 4'h0, hi_r = 4'h0, lo_r = 4'h0;
  logic [2:0] f_r = 3'h0;
  logic [1:0] calc_sr = 2'b00;
  logic       calc_en = 1'b1, calc_force = 1'b0, div_force = 1'b0, clr_cnt = 1'b0;
  logic [3:0] calc_v, lo_mux, hi_mux;
  logic [7:0] mul_v;
  logic [1:0] cap_opc = 2'b00, cap_sel = 2'b00, cap_selh = 2'b00;
  logic [19:0] outv;
  int en_cnt = 0, done_cnt = 0, xen_cnt = 0, mul_cyc = 0, div_cyc = 0, nidle = 0;
  int n_vec = 0, n_bad = 0;

  assign OP        = f_r;
  assign err_in    = (op_in == 3'b111) && (y_in == 4'h0);
  assign done_calc = (calc_sr[1] & calc_en) | calc_force;
  assign done_div  = div_force;
  assign outv = {cs, x_en, y_en, f_en, hi_en, lo_en, sel_lo, sel_hi, sel_p, op_calc,
                 go_calc, go_div, done, err};

  always_comb begin
    case (op_calc)
      2'b00:   calc_v = x_r + y_r;
      2'b01:   calc_v = x_r - y_r;
      2'b10:   calc_v = x_r & y_r;
      default: calc_v = x_r | y_r;
    endcase
    mul_v = {4'h0, x_r} * {4'h0, y_r};
    case (sel_lo)
      2'b00:   lo_mux = sel_p ? y_r : x_r;
      2'b01:   lo_mux = calc_v;
      2'b10:   lo_mux = mul_v[3:0];
      default: lo_mux = (y_r == 4'h0) ? 4'h0 : x_r / y_r;
    endcase
    case (sel_hi)
      2'b10:   hi_mux = mul_v[7:4];
      2'b11:   hi_mux = (y_r == 4'h0) ? 4'h0 : x_r % y_r;
      default: hi_mux = 4'h0;
    endcase
  end

  always @(posedge clk) begin
    if (x_en) x_r <= x_in;
    if (y_en) y_r <= y_in;
    if (f_en) f_r <= op_in;
    if (hi_en) hi_r <= hi_mux;
    if (lo_en) lo_r <= lo_mux;
    calc_sr <= {calc_sr[0], go_calc};
    if (go_calc) cap_opc <= op_calc;
    if (hi_en) begin
      cap_sel  <= sel_lo;
      cap_selh <= sel_hi;
    end
    if (clr_cnt) begin
      en_cnt <= 0; done_cnt <= 0; xen_cnt <= 0; mul_cyc <= 0; div_cyc <= 0; nidle <= 0;
    end else begin
      if (hi_en || lo_en)       en_cnt   <= en_cnt + 1;
      if (done)                 done_cnt <= done_cnt + 1;
      if (x_en || y_en || f_en) xen_cnt  <= xen_cnt + 1;
      if (cs == 4'd5)           mul_cyc  <= mul_cyc + 1;
      if (cs == 4'd7)           div_cyc  <= div_cyc + 1;
      if (cs != 4'd0)           nidle    <= nidle + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cs(input string tag, input logic [3:0] s, input int maxc);
    int n = 0;
    while (cs !== s && n < maxc) begin
      step();
      n++;
    end
    chk(tag, 32'(cs), 32'(s));
  endtask

  task automatic run_op(input string tag, input logic [3:0] x, input logic [3:0] y,
                        input logic [2:0] op, input int exp_lat);
    int lat = -1;
    x_in = x; y_in = y; op_in = op; go = 1'b1; clr_cnt = 1'b1;
    for (int i = 1; i <= 100 && lat < 0; i++) begin
      step();
      clr_cnt = 1'b0;
      go = 1'b0;
      if (done) lat = i;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    step();
  endtask

  logic [3:0] cx [4] = '{4'h5, 4'h3, 4'hC, 4'hC};
  logic [3:0] cy [4] = '{4'h3, 4'h5, 4'hA, 4'hA};
  logic [2:0] co [4] = '{3'b010, 3'b011, 3'b100, 3'b101};
  logic [3:0] cl [4] = '{4'h8, 4'hE, 4'h8, 4'hE};

  initial begin
    repeat (3) step();
    chk("reset_outs", 32'(outv), 32'h0);
    rst = 1'b1;
    repeat (2) step();

    // pass Y, cycle by cycle
    x_in = 4'h3; y_in = 4'hA; op_in = 3'b001; go = 1'b1; clr_cnt = 1'b1;
    step(); clr_cnt = 1'b0; go = 1'b0;
    chk("py_c1_cs", 32'(cs), 1);
    chk("py_c1_loads", 32'({x_en, y_en, f_en}), 7);
    step();
    chk("py_c2_cs", 32'(cs), 2);
    chk("py_c2_selp", 32'(sel_p), 1);
    step();
    chk("py_c3_cs", 32'(cs), 8);
    chk("py_c3_en", 32'({hi_en, lo_en}), 3);
    chk("py_c3_sel", 32'({sel_hi, sel_lo}), 0);
    step();
    chk("py_c4_done", 32'(done), 1);
    step();
    chk("py_idle", 32'({cs, done}), 0);
    chk("py_lo", 32'(lo_r), 32'hA);
    chk("py_hi", 32'(hi_r), 0);
    chk("py_en_cnt", 32'(en_cnt), 1);
    chk("py_done_cnt", 32'(done_cnt), 1);

    run_op("passx", 4'h3, 4'hA, 3'b000, 4);
    chk("px_lo", 32'(lo_r), 32'h3);

    for (int i = 0; i < 4; i++) begin
      run_op("calc", cx[i], cy[i], co[i], 7);
      chk("calc_opc", 32'(cap_opc), 32'(i));
      chk("calc_sel", 32'({cap_selh, cap_sel}), 32'h5);
      chk("calc_lo", 32'(lo_r), 32'(cl[i]));
      chk("calc_hi", 32'(hi_r), 0);
      chk("calc_done_cnt", 32'(done_cnt), 1);
    end

    run_op("mul", 4'h7, 4'h6, 3'b110, 7);
    chk("mul_wait_cyc", 32'(mul_cyc), 3);
    chk("mul_sel", 32'({cap_selh, cap_sel}), 32'hA);
    chk("mul_hi", 32'(hi_r), 2);
    chk("mul_lo", 32'(lo_r), 32'hA);

    // divide by zero: flagged at the go edge
    x_in = 4'h4; y_in = 4'h0; op_in = 3'b111; go = 1'b1; clr_cnt = 1'b1;
    step(); clr_cnt = 1'b0;
    chk("dz_cs", 32'(cs), 10);
    chk("dz_err", 32'(err), 1);
    repeat (2) step();
    chk("dz_err_held", 32'(err), 1);
    go = 1'b0;
    chk("dz_err_go_low", 32'(err), 1);
    step();
    chk("dz_err_clr", 32'({cs, err}), 0);
    chk("dz_no_en", 32'(en_cnt + xen_cnt), 0);
    chk("dz_keep", 32'({hi_r, lo_r}), 32'h2A);

    // stray engine done pulses while idle
    clr_cnt = 1'b1; step(); clr_cnt = 1'b0;
    calc_force = 1'b1; div_force = 1'b1;
    step();
    calc_force = 1'b0; div_force = 1'b0;
    step();
    chk("stray_idle", 32'(nidle + en_cnt), 0);

    // divider timeout
    x_in = 4'h9; y_in = 4'h2; op_in = 3'b111; go = 1'b1; clr_cnt = 1'b1;
    step(); clr_cnt = 1'b0; go = 1'b0;
    wait_cs("to_divgo", 4'd6, 10);
    repeat (32) step();
    chk("to_last_wait", 32'(cs), 7);
    step();
    chk("to_err", 32'({cs, err}), 32'h15);
    chk("to_wait_cyc", 32'(div_cyc), 32);
    chk("to_no_en", 32'(en_cnt), 0);
    step();
    chk("to_idle", 32'(cs), 0);
    chk("to_keep", 32'({hi_r, lo_r}), 32'h2A);

    // done_div on the limit cycle wins
    x_in = 4'hD; y_in = 4'h2; op_in = 3'b111; go = 1'b1; clr_cnt = 1'b1;
    step(); clr_cnt = 1'b0; go = 1'b0;
    wait_cs("sc_divgo", 4'd6, 10);
    repeat (32) step();
    div_force = 1'b1;
    chk("sc_last_wait", 32'(cs), 7);
    step();
    div_force = 1'b0;
    chk("sc_write", 32'({cs, hi_en}), 32'h11);
    step();
    chk("sc_done", 32'(done), 1);
    chk("sc_result", 32'({hi_r, lo_r}), 32'h16);
    chk("sc_sel", 32'(cap_sel), 3);
    step();

    // reset during CALC_WAIT with go held high
    calc_en = 1'b0;
    x_in = 4'h1; y_in = 4'h1; op_in = 3'b010; go = 1'b1; clr_cnt = 1'b1;
    step(); clr_cnt = 1'b0;
    wait_cs("rst_calcwait", 4'd4, 10);
    rst = 1'b0;
    #1;
    chk("rst_async", 32'(outv), 0);
    repeat (2) step();
    rst = 1'b1; clr_cnt = 1'b1;
    step(); clr_cnt = 1'b0;
    repeat (5) step();
    chk("rst_go_held", 32'(nidle + en_cnt), 0);
    go = 1'b0; calc_en = 1'b1;
    step();
    run_op("post_rst", 4'h5, 4'h3, 3'b010, 7);
    chk("post_rst_lo", 32'(lo_r), 32'h8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
